// File: rtl/reg_file_sb.sv
// Parametrised CPU register file: 2 combinational read ports, 1 write port, pending-write scoreboard, registered cpu_out mirror.
// Latency: reads are combinational; writes, busy bits, pending_cnt and cpu_out/out_strobe update at the CLK rise.
// Backpressure: none; strobes are sampled each edge. Optional write-to-read forwarding via macro REG_FILE_BYPASS_EN.
module reg_file_sb #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int OUT_IDX = (1 << ADDR_W) - 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  input  logic [ADDR_W-1:0] WA,
  input  logic [DATA_W-1:0] WD,
  input  logic              write_enable,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              RD1_valid,
  output logic              RD2_valid,
  output logic [DATA_W-1:0] cpu_out,
  output logic              out_strobe,
  output logic [ADDR_W:0]   pending_cnt
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] OUT_ADDR = ADDR_W'(OUT_IDX);

  logic [DATA_W-1:0] mem [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;
  logic [ADDR_W:0]   cnt_nxt;

  // Next busy vector: the clear from writeback is applied first so a same-address issue wins.
  always_comb begin
    busy_nxt = busy;
    if (write_enable) busy_nxt[WA] = 1'b0;
    if (issue_en)     busy_nxt[issue_addr] = 1'b1;
  end

  // Population count of the next busy vector, so pending_cnt always tracks busy exactly.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[i]);
    end
  end

  // Register storage; every index, including 0, is writable.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (write_enable) begin
      mem[WA] <= WD;
    end
  end

  // Scoreboard state and its registered pending count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      busy        <= '0;
      pending_cnt <= '0;
    end else begin
      busy        <= busy_nxt;
      pending_cnt <= cnt_nxt;
    end
  end

  // Mirror of the architectural output register with a one-cycle update pulse.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cpu_out    <= '0;
      out_strobe <= 1'b0;
    end else if (write_enable && (WA == OUT_ADDR)) begin
      cpu_out    <= WD;
      out_strobe <= 1'b1;
    end else begin
      out_strobe <= 1'b0;
    end
  end

  // Read ports; with forwarding, an in-flight write to the read address is returned as ready data.
  always_comb begin
    RD1       = mem[RA1];
    RD2       = mem[RA2];
    RD1_valid = ~busy[RA1];
    RD2_valid = ~busy[RA2];
`ifdef REG_FILE_BYPASS_EN
    if (write_enable && (WA == RA1)) begin
      RD1       = WD;
      RD1_valid = 1'b1;
    end
    if (write_enable && (WA == RA2)) begin
      RD2       = WD;
      RD2_valid = 1'b1;
    end
`endif
  end

endmodule
